// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requester blocks and the round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and an optional burst limit
// that preempts the owner after MAX_HOLD consecutive cycles when others are waiting.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_8_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  // With no limit the counter just saturates at its top value and is never consulted.
  localparam logic [7:0] HoldSat = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD);

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_q;
  logic [7:0] gnt_q;
  logic [2:0] idx_q;
  logic       valid_q;

  logic       others_req;
  logic       hold_limit;
  logic       rel;
  logic [2:0] start;
  logic [2:0] cand;
  logic [2:0] win_idx;
  logic       any_req;

  always_comb begin
    others_req = |(bus.req & ~gnt_q);
    hold_limit = (MAX_HOLD != 0) && (hold_q == HoldSat) && others_req;
    rel        = (state_q == StGrant) && (!bus.req[idx_q] || hold_limit);
    // A releasing owner hands top priority to its successor on this very edge.
    start      = rel ? idx_q + 3'd1 : ptr_q;
    win_idx    = 3'd0;
    any_req    = 1'b0;
    cand       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = start + 3'(i);
      if (!any_req && bus.req[cand]) begin
        win_idx = cand;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      hold_q  <= 8'd0;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q   <= 8'h01 << win_idx;
            idx_q   <= win_idx;
            valid_q <= 1'b1;
            hold_q  <= 8'd1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          if (rel) begin
            ptr_q <= idx_q + 3'd1;
            if (any_req) begin
              gnt_q   <= 8'h01 << win_idx;
              idx_q   <= win_idx;
              valid_q <= 1'b1;
              hold_q  <= 8'd1;
            end else begin
              gnt_q   <= 8'h00;
              idx_q   <= 3'd0;
              valid_q <= 1'b0;
              state_q <= StIdle;
            end
          end else if (hold_q != HoldSat) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter that owns one shared resource.
- Arbitrates to a 3-bit winner index, then decodes it to a one-hot grant vector (index n -> bit n).
- Grants are registered and held while the owner keeps requesting, subject to a configurable burst limit.
- Sits between the requester blocks and the shared datapath; gnt_idx drives the datapath select and gnt drives the per-requester enables.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles before the owner is preempted when another requester is pending.
  - 0 = unlimited hold.
  - Legal range 0..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request vector; bit n = requester n.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_idx  output  3  registered index of the current owner; 0 when idle.
- gnt_valid  output  1  registered; high when gnt is non-zero.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named rst.
- Reset values: state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, ptr=3'd0, hold_cnt=0.
  - rst asserted mid-grant clears gnt and gnt_valid immediately, without waiting for a clock edge.
- State machine: two states, IDLE and GRANT.
- Arbitration function (combinational):
  - Search req circularly starting at ptr: ptr, ptr+1, ..., ptr+7 (mod 8).
  - The first set bit wins, producing win_idx and any_req.
  - ptr is the highest-priority index.
- IDLE:
  - If any_req: at the next edge, gnt=1<<win_idx, gnt_idx=win_idx, gnt_valid=1, hold_cnt=1, state->GRANT.
  - Otherwise stay in IDLE with outputs zero.
- Latency: req sampled at edge N is reflected on gnt after edge N (one registered stage). No combinational path from req to gnt.
- GRANT, release condition: req[gnt_idx]==0, OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD AND any other req bit set).
- GRANT, on release:
  - ptr <= gnt_idx+1 (mod 8).
  - The arbitration result for the next edge uses the updated priority (gnt_idx+1 as the starting point), so the released owner has lowest priority.
  - If another requester exists, the grant switches directly at the same edge with no idle cycle: new gnt/gnt_idx, hold_cnt=1, stay in GRANT.
  - If no requester remains, go to IDLE with gnt=0, gnt_valid=0, gnt_idx=0.
- GRANT, no release: grant unchanged. hold_cnt increments and saturates at MAX_HOLD.
  - A sole requester at the limit therefore keeps the grant indefinitely.
  - With MAX_HOLD=0, hold_cnt is don't-care and is never used for preemption.
- A preempted owner that still requests re-enters arbitration at lowest priority and is re-granted only after the others are served or drop their requests.
- Invariants: gnt is always zero or exactly one-hot. gnt_valid == |gnt. gnt == (1<<gnt_idx) whenever gnt_valid=1.
- Requests are level-sensitive, with no latching: a req bit that pulses while another requester holds the grant is lost if it drops before being granted.
- Simultaneous requests: the circular priority from ptr decides. Index wrap 7->0 is handled by mod-8 arithmetic.

Test Plan:
- Reset and single request:
  - rst=1 with req=8'hFF -> gnt=0, gnt_valid=0 while reset is held.
  - Release rst with req=8'h04 -> after 1 edge, gnt=8'h04, gnt_idx=2, gnt_valid=1.
  - Drop req -> gnt=0 next edge.
- Round-robin fairness, MAX_HOLD=0:
  - req=8'hFF; each owner drops its bit for 1 cycle after 2 grant cycles.
  - Required grant order 0,1,2,...,7,0.
  - Transitions are back-to-back with no idle cycle.
- Burst preemption, MAX_HOLD=4:
  - req=8'h81 held constant -> gnt=8'h01 for exactly 4 cycles, then 8'h80 for 4, then 8'h01 again; repeats.
- Sole requester at limit, MAX_HOLD=4:
  - req=8'h10 for 10 cycles -> gnt=8'h10 continuously for all 10.
- Wrap-around priority:
  - Owner 7 releases while req=8'h41 -> next grant is idx 0 (8'h01), not 6.
- Async reset mid-grant:
  - gnt=8'h20; assert rst between clock edges -> gnt=0, gnt_valid=0 immediately.
  - After deassert with req=8'h60 -> first grant is idx 5 (ptr reset to 0).
